// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline stage registers: skid-stage state
// encoding, per-boundary widths and the control values that mark a bubble.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

    // IF/ID: pc4 + instruction; no control bundle, one dummy bit keeps widths legal
    localparam int IFID_DATA_W = 64;
    localparam int IFID_CTRL_W = 1;
    // ID/EX: da + db + imm + rn + sa; wreg, m2reg, wmem, aluc[3:0], aluimm, shift, jal
    localparam int IDEX_DATA_W = 106;
    localparam int IDEX_CTRL_W = 10;
    // EX/ME: ans + b + rw; wreg, wmem, rmem
    localparam int EXME_DATA_W = 69;
    localparam int EXME_CTRL_W = 3;
    // ME/WB: mo + alu + rw; wreg, m2reg
    localparam int MEWB_DATA_W = 69;
    localparam int MEWB_CTRL_W = 2;

    // A bubble must never write registers or memory, so all enables are low
    localparam logic [IFID_CTRL_W-1:0] IFID_BUBBLE_CTRL = '0;
    localparam logic [IDEX_CTRL_W-1:0] IDEX_BUBBLE_CTRL = '0;
    localparam logic [EXME_CTRL_W-1:0] EXME_BUBBLE_CTRL = '0;
    localparam logic [MEWB_CTRL_W-1:0] MEWB_BUBBLE_CTRL = '0;

    function automatic logic [1:0] state_occupancy(input stage_state_t s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// in_ready is registered so no combinational path runs from out_ready upstream.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = EXME_DATA_W,
    parameter int                CTRL_W      = EXME_CTRL_W,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
    input  logic              clock,
    input  logic              reset_0,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    stage_state_t r_state, w_state_nxt;
    entry_t       r_main, r_skid;
    entry_t       w_main_nxt, w_skid_nxt;
    entry_t       w_in_entry;
    logic         r_in_ready;
    logic         w_in_fire, w_out_fire;

    assign w_in_entry = {1'b1, in_ctrl, in_data};
    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_main.valid & out_ready;

    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;

        unique case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_main_nxt  = w_in_entry;
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nxt = w_in_entry;
                end else if (w_in_fire) begin
                    w_skid_nxt  = w_in_entry;
                    w_state_nxt = ST_TWO;
                end else if (w_out_fire) begin
                    w_main_nxt.valid = 1'b0;
                    w_state_nxt      = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_out_fire) begin
                    w_main_nxt       = r_skid;
                    w_skid_nxt.valid = 1'b0;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase

        // Flush wins over both handshakes; payload is left as-is, only valids drop
        if (flush) begin
            w_state_nxt      = ST_EMPTY;
            w_main_nxt.valid = 1'b0;
            w_skid_nxt.valid = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            // NOTE: the two entries are plain registers, not a memory, so clearing
            // them on reset is cheap and guarantees out_data=0 out of reset.
            r_state    <= ST_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main.valid;
    assign out_data  = r_main.data;
    assign out_ctrl  = r_main.valid ? r_main.ctrl : BUBBLE_CTRL;
    assign occupancy = state_occupancy(r_state);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized bench for pipe_stage_skid at EX/ME widths; the
// random phase checks delivery against a queue model of the two-entry buffer.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DW = EXME_DATA_W;
    localparam int CW = EXME_CTRL_W;
    typedef logic [DW-1:0] word_t;

    logic          clock;
    logic          reset_0;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [CW+DW-1:0] q[$];
    logic             m_in_fire, m_out_fire;

    pipe_stage_skid #(
        .DATA_W      (DW),
        .CTRL_W      (CW),
        .BUBBLE_CTRL (EXME_BUBBLE_CTRL)
    ) dut (
        .clock     (clock),
        .reset_0   (reset_0),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset with every input active
        reset_0   = 1'b0;
        in_valid  = 1'b1;
        in_data   = '1;
        in_ctrl   = '1;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", word_t'(out_valid), word_t'(0));
        check("rst_out_ctrl",  word_t'(out_ctrl),  word_t'(3'b000));
        check("rst_out_data",  out_data,           word_t'(0));
        check("rst_occupancy", word_t'(occupancy), word_t'(0));
        reset_0  = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("rst_in_ready_release", word_t'(in_ready), word_t'(1));
        tick();
        check("rst_in_ready_after", word_t'(in_ready), word_t'(1));
        check("rst_occ_after",      word_t'(occupancy), word_t'(0));

        // Full-rate stream 1..8
        out_ready = 1'b1;
        in_ctrl   = 3'b101;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = word_t'(i);
            tick();
            check("stream_data",  out_data,           word_t'(i));
            check("stream_valid", word_t'(out_valid), word_t'(1));
            check("stream_occ",   word_t'(occupancy), word_t'(1));
            check("stream_ready", word_t'(in_ready),  word_t'(1));
        end
        check("stream_ctrl", word_t'(out_ctrl), word_t'(3'b101));
        in_valid = 1'b0;
        tick();
        check("stream_drain_valid", word_t'(out_valid), word_t'(0));
        check("stream_drain_ctrl",  word_t'(out_ctrl),  word_t'(3'b000));

        // Backpressure: 1 in main, 2 in skid, 3 held upstream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = word_t'(1);
        tick();
        check("bp1_occ",   word_t'(occupancy), word_t'(1));
        check("bp1_ready", word_t'(in_ready),  word_t'(1));
        in_data = word_t'(2);
        tick();
        check("bp2_occ",   word_t'(occupancy), word_t'(2));
        check("bp2_ready", word_t'(in_ready),  word_t'(0));
        check("bp2_data",  out_data,           word_t'(1));
        in_data = word_t'(3);
        tick();
        check("bp3_hold_occ",  word_t'(occupancy), word_t'(2));
        check("bp3_hold_data", out_data,           word_t'(1));
        out_ready = 1'b1;
        tick();
        check("rec_data2", out_data,           word_t'(2));
        check("rec_occ",   word_t'(occupancy), word_t'(1));
        check("rec_ready", word_t'(in_ready),  word_t'(1));
        tick();
        check("rec_data3", out_data,           word_t'(3));
        check("rec_occ3",  word_t'(occupancy), word_t'(1));
        in_valid = 1'b0;
        tick();
        check("rec_empty", word_t'(occupancy), word_t'(0));

        // Flush in TWO with a new input offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = word_t'(4);
        tick();
        in_data = word_t'(5);
        tick();
        check("fl_pre_occ", word_t'(occupancy), word_t'(2));
        in_data = word_t'(9);
        flush   = 1'b1;
        tick();
        check("fl_occ",   word_t'(occupancy), word_t'(0));
        check("fl_valid", word_t'(out_valid), word_t'(0));
        check("fl_ctrl",  word_t'(out_ctrl),  word_t'(3'b000));
        check("fl_ready", word_t'(in_ready),  word_t'(1));
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("fl_no9_valid", word_t'(out_valid), word_t'(0));

        // Flush in ONE drops a simultaneously accepted input
        in_valid  = 1'b1;
        in_data   = word_t'(10);
        out_ready = 1'b0;
        tick();
        check("fl1_data", out_data, word_t'(10));
        in_data   = word_t'(11);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("fl1_occ",   word_t'(occupancy), word_t'(0));
        check("fl1_valid", word_t'(out_valid), word_t'(0));
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("fl1_no11", word_t'(out_valid), word_t'(0));

        // Asynchronous reset in TWO, asserted away from the clock edge
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = word_t'(6);
        tick();
        in_data = word_t'(7);
        tick();
        check("ar_pre_occ", word_t'(occupancy), word_t'(2));
        #2;
        reset_0 = 1'b0;
        #1;
        check("ar_occ",   word_t'(occupancy), word_t'(0));
        check("ar_valid", word_t'(out_valid), word_t'(0));
        check("ar_data",  out_data,           word_t'(0));
        check("ar_ctrl",  word_t'(out_ctrl),  word_t'(3'b000));
        check("ar_ready", word_t'(in_ready),  word_t'(1));
        in_valid = 1'b0;
        tick();
        reset_0 = 1'b1;
        tick();
        check("ar_rel_ready", word_t'(in_ready),  word_t'(1));
        check("ar_rel_occ",   word_t'(occupancy), word_t'(0));

        // Random handshake traffic against a queue model
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_data   = {$urandom(), $urandom(), 5'($urandom())};
            in_ctrl   = 3'($urandom());
            m_in_fire  = in_valid && (q.size() < 2);
            m_out_fire = (q.size() > 0) && out_ready;
            tick();
            if (m_out_fire) void'(q.pop_front());
            if (m_in_fire) q.push_back({in_ctrl, in_data});
            check("rnd_occ",   word_t'(occupancy), word_t'(q.size()));
            check("rnd_ready", word_t'(in_ready),  word_t'(q.size() < 2));
            check("rnd_valid", word_t'(out_valid), word_t'(q.size() > 0));
            if (q.size() > 0) begin
                check("rnd_data", out_data,          q[0][DW-1:0]);
                check("rnd_ctrl", word_t'(out_ctrl), word_t'(q[0][CW+DW-1:DW]));
            end else begin
                check("rnd_bubble", word_t'(out_ctrl), word_t'(3'b000));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register for the 5-stage MIPS pipeline; it generalises the fixed stage registers (IF/ID, ID/EX, EX/ME, ME/WB). It carries a data payload and a separate control bundle, and replaces the global enable with a valid/ready handshake backed by a 2-entry skid buffer. It supports synchronous flush and inserts bubbles by forcing the control bundle to a safe value whenever the stage holds no valid instruction. Every stage boundary instantiates it, with widths set per boundary.

## Interface
Parameters:
- DATA_W, 69, payload width (EX/ME: ans 32 + b 32 + rw 5)
- CTRL_W, 3, control bundle width (EX/ME: wreg, wmem, rmem)
- BUBBLE_CTRL, {CTRL_W{1'b0}}, value driven on out_ctrl when no valid entry is presented

Ports:
- clock  in  1  rising-edge clock
- reset_0  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream presents an instruction
- in_ready  out  1  stage can accept; registered, with no combinational path from out_ready
- in_data  in  DATA_W  upstream payload
- in_ctrl  in  CTRL_W  upstream control bundle
- flush  in  1  synchronous kill of all held entries
- out_valid  out  1  downstream entry valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head payload
- out_ctrl  out  CTRL_W  head control; equals BUBBLE_CTRL when out_valid=0
- occupancy  out  2  entries held (0, 1 or 2)

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage is a main entry (drives the outputs) and a skid entry. Each entry holds data, ctrl and a valid bit.
- States: EMPTY (occupancy 0), ONE (main valid), TWO (main and skid valid).
- Transitions from EMPTY:
  - in_fire: main ← in, go to ONE.
- Transitions from ONE:
  - in_fire & out_fire: main ← in, stay in ONE.
  - in_fire & !out_fire: skid ← in, go to TWO.
  - !in_fire & out_fire: go to EMPTY.
  - Otherwise: hold.
- Transitions from TWO:
  - out_fire: main ← skid, go to ONE.
  - Otherwise: hold.
  - In_fire cannot occur in TWO.
- in_ready = 1 in EMPTY and ONE, 0 in TWO. It is a registered function of the next state.
- out_valid = main valid. out_data = main data. out_ctrl = main valid ? main ctrl : BUBBLE_CTRL.
- Flush:
  - Next state is EMPTY and both valid bits clear.
  - Flush dominates a simultaneous in_fire: the input is dropped and upstream must treat it as consumed.
  - Flush also dominates a simultaneous out_fire: the consumer still samples the current head that cycle.
  - Payload registers are not cleared; only valid bits are.
- Ordering is strictly FIFO. There is no duplication or loss except on flush.
- Reset (any time, including mid-transfer):
  - State EMPTY; all payload and ctrl registers 0.
  - out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, occupancy=0.
  - in_ready=1 in the first cycle after reset_0 deasserts.

## Timing
- Latency: an entry accepted at edge N is presented on out_* after edge N, i.e. one cycle.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- Backpressure: after out_ready drops, the stage accepts at most one further entry, then in_ready falls at the next edge.
- Recovery: when out_ready returns with the stage in TWO, in_ready rises one edge later.
- Outputs change only on the rising clock edge, or asynchronously when reset_0 asserts.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (ST_EMPTY, ST_ONE, ST_TWO);
  - per-boundary width constants (IFID_DATA_W, IDEX_DATA_W, EXME_DATA_W, EXME_CTRL_W, MEWB_DATA_W, ...);
  - bubble control constants.
- The block is a single module with no sub-modules. Entry storage is two {valid, ctrl, data} registers; the next-state logic is one combinational block.

## Test plan
- Reset with all inputs active → out_valid=0, out_ctrl=3'b000, out_data=0, occupancy=0. After release, in_ready=1.
- Stream of 8 entries (in_data=1..8, in_ctrl=3'b101), out_ready=1 throughout → out_data 1..8 on consecutive cycles, one-cycle latency, occupancy stays 1.
- out_ready=0 while streaming 1,2,3 → 1 in main, 2 in skid, in_ready=0, and 3 held upstream. Raising out_ready then gives 1,2,3 in order with no gaps beyond one cycle.
- flush in state TWO asserted together with in_valid (in_data=9) → next cycle occupancy=0, out_valid=0, out_ctrl=BUBBLE_CTRL, and 9 never appears.
- reset_0 pulsed low mid-stream in state TWO, off the clock edge → outputs clear immediately, without waiting for the next clock edge.
- Random valid/ready stimulus over 10k cycles → scoreboard shows in-order, lossless delivery; in_ready is never 1 while occupancy=2.
